// File: rtl/digit_serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// Optional overflow flag is gated by DIGIT_SERIAL_ADDER_OVF_EN.
package digit_serial_adder_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned digits_of(
    input int unsigned w,
    input int unsigned d
  );
    return w / d;
  endfunction

  function automatic int unsigned cnt_width(
    input int unsigned n
  );
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-wide combinational ripple-carry slice built from full adders.
// Reused per cycle by the digit-serial adder datapath.
module digit_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int unsigned DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i])
                  | (x[i] & c[i])
                  | (y[i] & c[i]);
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle WIDTH-bit adder, one DIGIT-bit slice per clock, LSB first.
// Define DIGIT_SERIAL_ADDER_OVF_EN to add the signed overflow output.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned DIGITS = digits_of(WIDTH, DIGIT);
  localparam int unsigned CW     = cnt_width(DIGITS);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_bad_cfg
    $error("WIDTH must be a nonzero multiple of DIGIT");
  end

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    idx_q, idx_d;

  logic             accept;
  logic             running;
  logic             last;
  logic [DIGIT-1:0] slice_x;
  logic [DIGIT-1:0] slice_y;
  logic [DIGIT-1:0] slice_s;
  logic             slice_co;
  int unsigned      off;

  // Single shared slice; the digit mux picks the active operand digit.
  digit_adder #(
    .DIGIT (DIGIT)
  ) u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign accept  = in_valid && in_ready;
  assign running = (state_q == RUN);
  assign last    = (idx_q == LAST);

  always_comb begin
    off     = int'(idx_q) * DIGIT;
    slice_x = a_q[off +: DIGIT];
    slice_y = b_q[off +: DIGIT];
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    unique case (1'b1)
      accept: begin
        a_d     = a;
        b_d     = b;
        carry_d = cin;
        sum_d   = '0;
        idx_d   = '0;
      end
      running: begin
        sum_d[off +: DIGIT] = slice_s;
        carry_d = slice_co;
        idx_d   = last ? '0 : idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_q;

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // Sampled on the final digit, when sum_d already holds the result MSB.
  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      ovf_d = 1'b0;
    end else if (running && last) begin
      ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1])
           && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Randomized self-checking bench for digit_serial_adder.
// Reference is plain integer addition of the captured operands.
module tb_digit_serial_adder;

  localparam int W = 16;
  localparam int D = 4;
  localparam int NDIG = W / D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  digit_serial_adder #(
    .WIDTH (W),
    .DIGIT (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(
    input logic [W-1:0] ta,
    input logic [W-1:0] tb_,
    input logic         tc,
    input int           hold,
    input string        tag
  );
    logic [W:0] exp;
    logic       exp_ovf;
    int         n;
    exp = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
    exp_ovf = (ta[W-1] == tb_[W-1]) && (exp[W-1] != ta[W-1]);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    a = ta;
    b = tb_;
    cin = tc;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 20);
    check_eq({tag, "_lat"}, 32'(n), 32'(NDIG));
    for (int i = 0; i < hold; i++) begin
      check_eq({tag, "_hv"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_hs"}, 32'(sum), 32'(exp[W-1:0]));
      check_eq({tag, "_hr"}, 32'(in_ready), 32'd0);
      tick();
    end
    check_eq({tag, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
    check_eq({tag, "_co"}, 32'(carry_out), 32'(exp[W]));
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf) n = 0;
`endif
    out_ready = 1'b1;
    tick();
    check_eq({tag, "_idle_v"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_idle_r"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int v1;
    int v2;
    logic [W:0] e1;
    logic [W:0] e2;
    logic [W-1:0] s1;
    logic [W-1:0] s2;

    #12;
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_co", 32'(carry_out), 32'd0);
    check_eq("rst_vld", 32'(out_valid), 32'd0);
    check_eq("rst_rdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    run_op(16'h00FF, 16'h0001, 1'b0, 0, "t1");
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, "t2a");
    run_op(16'h1234, 16'h1111, 1'b1, 0, "t2b");
    run_op(16'hABCD, 16'h1111, 1'b0, 5, "t3");

    // Held in_valid with changed operands must not disturb the op in flight.
    e1 = 17'h01111 + 17'h02222;
    e2 = 17'h0F0F0 + 17'h00F0F + 17'd1;
    v1 = -1;
    v2 = -1;
    s1 = '0;
    s2 = '0;
    a = 16'h1111;
    b = 16'h2222;
    cin = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      tick();
      if (cyc == 0) begin
        a = 16'hF0F0;
        b = 16'h0F0F;
        cin = 1'b1;
      end
      if (cyc == 6) in_valid = 1'b0;
      if (out_valid && v1 < 0) begin
        v1 = cyc;
        s1 = sum;
      end else if (out_valid && v2 < 0) begin
        v2 = cyc;
        s2 = sum;
      end
    end
    out_ready = 1'b0;
    check_eq("t4_v1", 32'(v1), 32'd4);
    check_eq("t4_s1", 32'(s1), 32'(e1[W-1:0]));
    check_eq("t4_v2", 32'(v2), 32'd10);
    check_eq("t4_s2", 32'(s2), 32'(e2[W-1:0]));

    // Abort mid-run with non-zero partial sum, then verify a clean op.
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_sum", 32'(sum), 32'd0);
    check_eq("t5_co", 32'(carry_out), 32'd0);
    check_eq("t5_vld", 32'(out_valid), 32'd0);
    check_eq("t5_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(16'h0003, 16'h0004, 1'b0, 0, "t5b");

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, "t6a");
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, "t6b");
`endif

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
